// File: rtl/lrwait_qnode_multi.sv
// lrwait_qnode_multi: per-core LRWait/SCWait queue node with multiple concurrent reservation slots
module lrwait_qnode_multi #(
  parameter int unsigned NumSlots    = 2,
  parameter int unsigned MetaWidth   = 16,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned MetaIdWidth = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   snitch_qaddr_i,
  input  logic                   snitch_qwrite_i,
  input  logic [3:0]             snitch_qamo_i,
  input  logic [31:0]            snitch_qdata_i,
  input  logic [3:0]             snitch_qstrb_i,
  input  logic [MetaIdWidth-1:0] snitch_qid_i,
  input  logic                   snitch_qvalid_i,
  output logic                   snitch_qready_o,
  output logic [31:0]            snitch_pdata_o,
  output logic                   snitch_perror_o,
  output logic [MetaIdWidth-1:0] snitch_pid_o,
  output logic                   snitch_pvalid_o,
  input  logic                   snitch_pready_i,
  output logic [AddrWidth-1:0]   tile_qaddr_o,
  output logic                   tile_qwrite_o,
  output logic [3:0]             tile_qamo_o,
  output logic [31:0]            tile_qdata_o,
  output logic [3:0]             tile_qstrb_o,
  output logic [MetaIdWidth-1:0] tile_qid_o,
  output logic                   tile_qlrwait_o,
  output logic                   tile_qvalid_o,
  input  logic                   tile_qready_i,
  input  logic [31:0]            tile_pdata_i,
  input  logic                   tile_perror_i,
  input  logic [MetaIdWidth-1:0] tile_pid_i,
  input  logic                   tile_plrwait_i,
  input  logic                   tile_pvalid_i,
  output logic                   tile_pready_o,
  output logic [NumSlots-1:0]    slots_busy_o
);
  localparam int unsigned IdxW = NumSlots > 1 ? $clog2(NumSlots) : 1;
  localparam logic [3:0] AmoLrWait = 4'hC;
  localparam logic [3:0] AmoScWait = 4'hD;
  typedef enum logic [1:0] {Idle, Ready, Queue, Wake} state_t;
  state_t                 state      [NumSlots];
  logic [AddrWidth-1:0]   addr       [NumSlots];
  logic [MetaIdWidth-1:0] instr_id   [NumSlots];
  logic [MetaWidth-1:0]   meta       [NumSlots];
  logic [NumSlots-1:0]    valid, sc_arrived;
  logic [NumSlots-1:0]    match_q, match_p, alloc, sc_now, succ_now, rsp_now;
  logic [IdxW-1:0]        free_idx, wake_idx;
  logic                   free_any, wake_any, is_lr, is_sc, lr_stall, q_hs, p_hs, wake_hs;
  assign is_lr = snitch_qamo_i == AmoLrWait;
  assign is_sc = snitch_qamo_i == AmoScWait;
  // an LRWait needs a free slot and must not reserve an address that is already held
  assign lr_stall = is_lr && (!free_any || |match_q);
  assign snitch_qready_o = !rst_i && !wake_any && !lr_stall && tile_qready_i;
  assign tile_qvalid_o   = !rst_i && (wake_any || (snitch_qvalid_i && !lr_stall));
  assign q_hs    = snitch_qvalid_i && snitch_qready_o;
  assign wake_hs = !rst_i && wake_any && tile_qready_i;
  assign tile_qaddr_o   = wake_any ? addr[wake_idx] : snitch_qaddr_i;
  assign tile_qwrite_o  = !wake_any && snitch_qwrite_i;
  assign tile_qamo_o    = wake_any ? AmoLrWait : snitch_qamo_i;
  assign tile_qdata_o   = wake_any ? 32'(meta[wake_idx]) : snitch_qdata_i;
  assign tile_qstrb_o   = wake_any ? 4'h0 : snitch_qstrb_i;
  assign tile_qid_o     = snitch_qid_i;
  assign tile_qlrwait_o = wake_any;
  // SuccUpdates are always swallowed here; everything else is wired through
  assign tile_pready_o   = !rst_i && (tile_plrwait_i || snitch_pready_i);
  assign snitch_pvalid_o = !rst_i && tile_pvalid_i && !tile_plrwait_i;
  assign snitch_pdata_o  = tile_pdata_i;
  assign snitch_perror_o = tile_perror_i;
  assign snitch_pid_o    = tile_pid_i;
  assign p_hs = tile_pvalid_i && tile_pready_o;
  // slot lookup plus lowest-index priority pick for allocation and WakeUp injection
  always_comb begin
    free_any = 1'b0;
    wake_any = 1'b0;
    free_idx = '0;
    wake_idx = '0;
    match_q = '0;
    match_p = '0;
    alloc = '0;
    sc_now = '0;
    succ_now = '0;
    rsp_now = '0;
    slots_busy_o = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      match_q[i] = valid[i] && addr[i] == snitch_qaddr_i;
      match_p[i] = valid[i] && instr_id[i] == tile_pid_i;
      slots_busy_o[i] = !rst_i && state[i] != Idle;
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
      if (state[i] == Wake) begin
        wake_any = 1'b1;
        wake_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < NumSlots; i++) begin
      alloc[i]    = q_hs && is_lr && !valid[i] && free_idx == IdxW'(i);
      sc_now[i]   = q_hs && is_sc && match_q[i];
      succ_now[i] = p_hs && tile_plrwait_i && match_p[i];
      rsp_now[i]  = p_hs && !tile_plrwait_i && match_p[i];
    end
  end
  // per-slot reservation state machine
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        state[i] <= Idle;
        valid[i] <= 1'b0;
        sc_arrived[i] <= 1'b0;
        addr[i] <= '0;
        instr_id[i] <= '0;
        meta[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (alloc[i]) begin
          valid[i] <= 1'b1;
          addr[i] <= snitch_qaddr_i;
          instr_id[i] <= snitch_qid_i;
        end
        case (state[i])
          Idle: begin
            if (succ_now[i]) begin
              state[i] <= Queue;
              meta[i] <= tile_pdata_i[MetaWidth-1:0];
            end else if (rsp_now[i]) state[i] <= Ready;
          end
          Ready: begin
            if (sc_now[i]) begin
              instr_id[i] <= snitch_qid_i;
              sc_arrived[i] <= 1'b1;
            end
            if (succ_now[i]) begin
              state[i] <= (sc_arrived[i] || sc_now[i]) ? Wake : Queue;
              meta[i] <= tile_pdata_i[MetaWidth-1:0];
            end else if (rsp_now[i] && sc_arrived[i]) begin
              state[i] <= Idle;
              valid[i] <= 1'b0;
              sc_arrived[i] <= 1'b0;
            end
          end
          Queue: begin
            if (sc_now[i]) begin
              state[i] <= Wake;
              instr_id[i] <= snitch_qid_i;
            end
          end
          default: begin
            if (wake_hs && wake_idx == IdxW'(i)) begin
              state[i] <= Idle;
              valid[i] <= 1'b0;
              sc_arrived[i] <= 1'b0;
            end
          end
        endcase
      end
    end
  end
  // ambiguous lookups and orphaned SuccUpdates indicate a protocol violation upstream
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (snitch_qvalid_i) assert ($onehot0(match_q));
      if (tile_pvalid_i) assert ($onehot0(match_p));
      if (tile_pvalid_i && tile_plrwait_i) assert (|match_p);
    end
  end
endmodule

// File: tb/tb_lrwait_qnode_multi.sv
// tb_lrwait_qnode_multi: vector table plus WakeUp scoreboard for the LRWait queue node
module tb_lrwait_qnode_multi;
  localparam logic [3:0] LR = 4'hC;
  localparam logic [3:0] SC = 4'hD;
  logic clk = 0, rst = 1;
  logic [31:0] qaddr, qdata, pdata, tqaddr, tqdata, spdata;
  logic [3:0] qamo, qstrb, tqamo, tqstrb;
  logic [5:0] qid, pid, tqid, spid;
  logic qwrite, qvalid, sqready, sperror, spvalid, spready;
  logic tqwrite, tqlrwait, tqvalid, tqready, perror, plrwait, pvalid, tpready;
  logic [1:0] busy;
  int total = 0, bad = 0;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wake_t;
  wake_t sb[$];
  wake_t mon_e;
  typedef struct { logic qv; logic [3:0] amo; logic tqr; logic pv; logic pr; logic e_qr; logic e_tqv; logic e_pv; logic e_pr; } vec_t;
  vec_t vt[8];

  lrwait_qnode_multi dut (
    .clk_i(clk), .rst_i(rst),
    .snitch_qaddr_i(qaddr), .snitch_qwrite_i(qwrite), .snitch_qamo_i(qamo), .snitch_qdata_i(qdata),
    .snitch_qstrb_i(qstrb), .snitch_qid_i(qid), .snitch_qvalid_i(qvalid), .snitch_qready_o(sqready),
    .snitch_pdata_o(spdata), .snitch_perror_o(sperror), .snitch_pid_o(spid), .snitch_pvalid_o(spvalid),
    .snitch_pready_i(spready),
    .tile_qaddr_o(tqaddr), .tile_qwrite_o(tqwrite), .tile_qamo_o(tqamo), .tile_qdata_o(tqdata),
    .tile_qstrb_o(tqstrb), .tile_qid_o(tqid), .tile_qlrwait_o(tqlrwait), .tile_qvalid_o(tqvalid),
    .tile_qready_i(tqready),
    .tile_pdata_i(pdata), .tile_perror_i(perror), .tile_pid_i(pid), .tile_plrwait_i(plrwait),
    .tile_pvalid_i(pvalid), .tile_pready_o(tpready), .slots_busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    qvalid = 0; qaddr = 0; qwrite = 0; qamo = 0; qdata = 0; qstrb = 0; qid = 0;
    pvalid = 0; plrwait = 0; pdata = 0; perror = 0; pid = 0; tqready = 1; spready = 1;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_in();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic req(input logic [3:0] amo, input logic [31:0] a, input logic [5:0] id);
    int n = 0;
    qvalid = 1; qamo = amo; qaddr = a; qid = id; qwrite = 0; qdata = 0; qstrb = 4'hF;
    #1;
    while (!sqready && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("req_accept", 32'(sqready), 1);
    chk("req_fwd_addr", tqaddr, a);
    tick();
    qvalid = 0;
  endtask

  task automatic resp(input logic [5:0] id, input logic lr, input logic [31:0] d);
    pvalid = 1; pid = id; plrwait = lr; pdata = d;
    #1;
    chk("rsp_pvalid", 32'(spvalid), lr ? 0 : 1);
    chk("rsp_pready", 32'(tpready), lr ? 1 : 32'(spready));
    if (!lr) chk("rsp_pdata", spdata, d);
    tick();
    pvalid = 0; plrwait = 0;
  endtask

  // every accepted WakeUp must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && tqvalid && tqlrwait && tqready) begin
      if (sb.size() == 0) chk("wake_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("wake_addr", tqaddr, mon_e.addr);
        chk("wake_data", tqdata, mon_e.data);
        chk("wake_amo", 32'(tqamo), 32'(LR));
        chk("wake_strb", 32'(tqstrb), 0);
        chk("wake_write", 32'(tqwrite), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    idle_in();
    qvalid = 1; pvalid = 1;
    #2;
    chk("rst_qready", 32'(sqready), 0);
    chk("rst_tqvalid", 32'(tqvalid), 0);
    chk("rst_pvalid", 32'(spvalid), 0);
    chk("rst_pready", 32'(tpready), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();
    // passthrough vectors with no reservation held
    vt[0] = '{1, 4'h0, 1, 0, 1, 1, 1, 0, 1};
    vt[1] = '{1, 4'h0, 0, 0, 1, 0, 1, 0, 1};
    vt[2] = '{0, 4'h0, 1, 0, 1, 1, 0, 0, 1};
    vt[3] = '{1, SC,   1, 0, 0, 1, 1, 0, 0};
    vt[4] = '{1, LR,   0, 0, 1, 0, 1, 0, 1};
    vt[5] = '{0, 4'h0, 1, 1, 0, 1, 0, 1, 0};
    vt[6] = '{1, 4'hB, 1, 1, 1, 1, 1, 1, 1};
    vt[7] = '{1, SC,   0, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      qvalid = vt[i].qv; qamo = vt[i].amo; tqready = vt[i].tqr; pvalid = vt[i].pv; spready = vt[i].pr;
      qaddr = 32'h1000 + 32'(i * 4); pdata = 32'hA0 + 32'(i); pid = 6'(40 + i);
      #1;
      chk("vec_qready", 32'(sqready), 32'(vt[i].e_qr));
      chk("vec_tqvalid", 32'(tqvalid), 32'(vt[i].e_tqv));
      chk("vec_pvalid", 32'(spvalid), 32'(vt[i].e_pv));
      chk("vec_pready", 32'(tpready), 32'(vt[i].e_pr));
      chk("vec_addr", tqaddr, qaddr);
      chk("vec_lrwait", 32'(tqlrwait), 0);
      chk("vec_pdata", spdata, pdata);
      tick();
    end
    idle_in();
    chk("vec_busy", 32'(busy), 0);
    // 1: plain LRWait/SCWait, no WakeUp
    do_reset();
    req(LR, 32'h100, 3);
    resp(3, 0, 32'h0);
    chk("t1_busy_ready", 32'(busy), 1);
    req(SC, 32'h100, 4);
    resp(4, 0, 32'h1);
    chk("t1_busy_end", 32'(busy), 0);
    // 2: queued LRWait, SuccUpdate metadata carried by WakeUp
    do_reset();
    req(LR, 32'h100, 3);
    spready = 0;
    resp(3, 1, 32'h2A5);
    spready = 1;
    chk("t2_busy_q", 32'(busy), 1);
    sb.push_back('{32'h100, 32'h2A5});
    req(SC, 32'h100, 4);
    #1;
    chk("t2_wake_lrwait", 32'(tqlrwait), 1);
    chk("t2_wake_blocks", 32'(sqready), 0);
    tick();
    chk("t2_busy_end", 32'(busy), 0);
    resp(4, 0, 32'h1234);
    // 3: two pending WakeUps drain lowest index first on consecutive cycles
    do_reset();
    req(LR, 32'h100, 1);
    req(LR, 32'h200, 2);
    resp(1, 0, 0);
    resp(2, 0, 0);
    chk("t3_busy_both", 32'(busy), 3);
    req(SC, 32'h100, 7);
    req(SC, 32'h200, 8);
    tqready = 0;
    sb.push_back('{32'h100, 32'hAA});
    resp(7, 1, 32'hAA);
    sb.push_back('{32'h200, 32'hBB});
    resp(8, 1, 32'hBB);
    #1;
    chk("t3_first_addr", tqaddr, 32'h100);
    chk("t3_busy_wake", 32'(busy), 3);
    tqready = 1;
    #1;
    chk("t3_first_valid", 32'(tqvalid), 1);
    tick();
    chk("t3_second_addr", tqaddr, 32'h200);
    chk("t3_second_valid", 32'(tqvalid), 1);
    tick();
    chk("t3_drained", 32'(tqvalid), 0);
    chk("t3_busy_end", 32'(busy), 0);
    // 4: full node stalls a third LRWait until a slot frees
    do_reset();
    req(LR, 32'h100, 1);
    req(LR, 32'h200, 2);
    resp(1, 0, 0);
    resp(2, 0, 0);
    req(SC, 32'h200, 10);
    qvalid = 1; qamo = LR; qaddr = 32'h300; qid = 9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_full_qready", 32'(sqready), 0);
      chk("t4_full_tqvalid", 32'(tqvalid), 0);
      tick();
    end
    pvalid = 1; pid = 10; plrwait = 0;
    #1;
    chk("t4_still_full", 32'(sqready), 0);
    tick();
    pvalid = 0;
    #1;
    chk("t4_freed_qready", 32'(sqready), 1);
    tick();
    qvalid = 0;
    resp(9, 0, 0);
    chk("t4_busy_refill", 32'(busy), 3);
    qvalid = 1; qamo = LR; qaddr = 32'h300; qid = 11;
    #1;
    chk("t4_dup_addr_stall", 32'(sqready), 0);
    tick();
    qvalid = 0;
    // 5: SCWait and SuccUpdate in the same cycle from ReadyForSCWait
    do_reset();
    req(LR, 32'h100, 1);
    resp(1, 0, 0);
    chk("t5_busy_ready", 32'(busy), 1);
    qvalid = 1; qamo = SC; qaddr = 32'h100; qid = 2;
    pvalid = 1; plrwait = 1; pid = 1; pdata = 32'h55;
    sb.push_back('{32'h100, 32'h55});
    #1;
    chk("t5_sc_qready", 32'(sqready), 1);
    chk("t5_succ_pvalid", 32'(spvalid), 0);
    chk("t5_succ_pready", 32'(tpready), 1);
    tick();
    qvalid = 0; pvalid = 0; plrwait = 0;
    #1;
    chk("t5_wake_valid", 32'(tqvalid), 1);
    chk("t5_wake_lrwait", 32'(tqlrwait), 1);
    tick();
    chk("t5_busy_end", 32'(busy), 0);
    // 6: WakeUp held under backpressure, then discarded by reset
    do_reset();
    req(LR, 32'h100, 1);
    resp(1, 1, 32'h77);
    req(SC, 32'h100, 2);
    tqready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_hold_valid", 32'(tqvalid), 1);
      chk("t6_hold_addr", tqaddr, 32'h100);
      chk("t6_hold_data", tqdata, 32'h77);
      tick();
    end
    rst = 1;
    #1;
    chk("t6_rst_tqvalid", 32'(tqvalid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 0;
    tqready = 1;
    #1;
    chk("t6_post_tqvalid", 32'(tqvalid), 0);
    chk("t6_post_lrwait", 32'(tqlrwait), 0);
    chk("t6_post_busy", 32'(busy), 0);
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
